pc_sequencer: RTL and testbench

Owns the program counter register for the 5-stage MIPS pipeline and drives the select for the next-PC mux.
Arbitrates between four next-PC sources in fixed priority: exception, branch (EX), jump (ID), sequential.
Runs the instruction-memory fetch handshake and holds any redirect that arrives while a fetch is outstanding.
Raises IF/ID flushes on redirect.

---
 rtl/pc_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter of the 5-stage MIPS pipeline. Picks the next PC
// from four sources in fixed priority (exception > branch > jump > sequential),
// runs the instruction-memory fetch handshake, parks a redirect that arrives
// while a fetch is still outstanding, and raises the IF/ID flush pulses.
//
// Build option:
//   DELAY_SLOT_EN - branches and jumps get an architectural delay slot. The
//                   target is parked in a one-deep deferred register and
//                   replaces the PC increment of the next completed
//                   sequential fetch. Exceptions still redirect immediately
//                   and cancel any deferred target.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset_n      synchronous active-low reset
//   i_stall        hazard-unit hold of the IF stage
//   o_imem_req     fetch request to instruction memory
//   i_imem_ready   fetch for o_imem_addr completes this cycle
//   o_imem_addr    fetch address (always equals o_pc)
//   i_br_taken     branch resolved taken in EX (pulse)
//   i_br_target    branch target
//   i_jmp_valid    jump decoded in ID (pulse)
//   i_jmp_target   jump target
//   i_exc_valid    exception raised in MEM (pulse)
//   i_exc_pc       PC of the faulting instruction
//   o_pc           current PC register
//   o_pc_plus4     o_pc + PC_INC
//   o_pc_sel       next-PC select: 0 seq, 1 jump, 2 branch, 3 exception
//   o_epc          saved exception PC
//   o_fetch_valid  instruction returned this cycle is to be kept
//   o_flush_if     kill IF/ID register contents
//   o_flush_id     kill ID/EX register contents
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter logic [31:0] PC_INC       = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    output logic        o_imem_req,
    input  logic        i_imem_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_jmp_valid,
    input  logic [31:0] i_jmp_target,
    input  logic        i_exc_valid,
    input  logic [31:0] i_exc_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [1:0]  o_pc_sel,
    output logic [31:0] o_epc,
    output logic        o_fetch_valid,
    output logic        o_flush_if,
    output logic        o_flush_id
);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_e;

    localparam logic [1:0]  SEL_SEQ    = 2'd0;
    localparam logic [1:0]  SEL_JMP    = 2'd1;
    localparam logic [1:0]  SEL_BR     = 2'd2;
    localparam logic [1:0]  SEL_EXC    = 2'd3;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_epc;
    logic [31:0] w_epc_next;
    logic [31:0] r_pending;
    logic [31:0] w_pending_next;

    logic        w_active;      // out of reset and past the boot cycle
    logic [1:0]  w_win_sel;
    logic [31:0] w_win_target;
    logic        w_redir;       // redirect acting on the fetch stream this cycle
    logic        w_seq_taken;   // sequential fetch completes this cycle
    logic [31:0] w_pc_plus4;
    logic [31:0] w_seq_next;

    assign w_pc_plus4 = r_pc + PC_INC;
    assign w_active   = i_reset_n && (r_state != StBoot);

    // Fixed-priority winner; lower-priority requests in the same cycle are dropped.
    always_comb begin
        w_win_sel    = SEL_SEQ;
        w_win_target = w_pc_plus4;
        if (i_exc_valid) begin
            w_win_sel    = SEL_EXC;
            w_win_target = EXC_VECTOR & ALIGN_MASK;
        end else if (i_br_taken) begin
            w_win_sel    = SEL_BR;
            w_win_target = i_br_target & ALIGN_MASK;
        end else if (i_jmp_valid) begin
            w_win_sel    = SEL_JMP;
            w_win_target = i_jmp_target & ALIGN_MASK;
        end
    end

`ifdef DELAY_SLOT_EN
    // Only exceptions redirect at once; branches and jumps are deferred.
    assign w_redir = w_active && i_exc_valid;
`else
    assign w_redir = w_active && (w_win_sel != SEL_SEQ);
`endif

    assign w_seq_taken = w_active && (r_state == StFetch) && !w_redir &&
                         !i_stall && i_imem_ready;

`ifdef DELAY_SLOT_EN
    logic        r_defer_valid;
    logic        w_defer_valid_next;
    logic [31:0] r_defer_target;
    logic [31:0] w_defer_target_next;

    // The deferred target replaces the increment of the next sequential fetch
    // that completes; a fresh branch/jump in that same cycle re-arms it.
    always_comb begin
        w_defer_valid_next  = r_defer_valid;
        w_defer_target_next = r_defer_target;
        w_seq_next          = r_defer_valid ? r_defer_target : w_pc_plus4;
        if (w_seq_taken) begin
            w_defer_valid_next = 1'b0;
        end
        if (w_active && !i_exc_valid && (i_br_taken || i_jmp_valid)) begin
            w_defer_valid_next  = 1'b1;
            w_defer_target_next = w_win_target;
        end
        if (w_redir) begin
            w_defer_valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_defer_valid  <= 1'b0;
            r_defer_target <= '0;
        end else begin
            r_defer_valid  <= w_defer_valid_next;
            r_defer_target <= w_defer_target_next;
        end
    end
`else
    assign w_seq_next = w_pc_plus4;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_epc_next     = r_epc;
        w_pending_next = r_pending;
        o_imem_req     = 1'b0;
        o_fetch_valid  = 1'b0;
        o_flush_if     = 1'b0;
        o_flush_id     = 1'b0;
        o_pc_sel       = w_active ? w_win_sel : SEL_SEQ;

        // Flushes come straight from the pulsed request, so each redirect
        // event yields exactly one cycle of flush.
        if (w_redir) begin
            o_flush_if = 1'b1;
            o_flush_id = (w_win_sel != SEL_JMP);
            if (i_exc_valid) begin
                w_epc_next = i_exc_pc;
            end
        end

        unique case (r_state)
            StBoot: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                o_imem_req = 1'b1;
                if (w_redir) begin
                    // Redirect overrides stall.
                    if (i_imem_ready) begin
                        w_pc_next = w_win_target;
                    end else begin
                        w_pending_next = w_win_target;
                        w_state_next   = StHold;
                    end
                end else if (w_seq_taken) begin
                    o_fetch_valid = 1'b1;
                    w_pc_next     = w_seq_next;
                end
            end
            StHold: begin
                // Outstanding fetch drains and is discarded; latest redirect wins.
                o_imem_req = 1'b1;
                if (w_redir) begin
                    w_pending_next = w_win_target;
                end
                if (i_imem_ready) begin
                    w_pc_next    = w_redir ? w_win_target : r_pending;
                    w_state_next = StFetch;
                end
            end
            default: begin
                w_state_next = StBoot;
            end
        endcase

        if (!i_reset_n) begin
            o_imem_req    = 1'b0;
            o_fetch_valid = 1'b0;
            o_flush_if    = 1'b0;
            o_flush_id    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= StBoot;
            r_pc      <= RESET_VECTOR;
            r_epc     <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_epc     <= w_epc_next;
            r_pending <= w_pending_next;
        end
    end

    assign o_pc        = r_pc;
    assign o_imem_addr = r_pc;
    assign o_pc_plus4  = w_pc_plus4;
    assign o_epc       = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan sequences followed by random
// stimulus, all checked against a transaction-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_sel;
    logic [31:0] epc;
    logic        fetch_valid;
    logic        flush_if;
    logic        flush_id;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_stall      (stall),
        .o_imem_req   (imem_req),
        .i_imem_ready (imem_ready),
        .o_imem_addr  (imem_addr),
        .i_br_taken   (br_taken),
        .i_br_target  (br_target),
        .i_jmp_valid  (jmp_valid),
        .i_jmp_target (jmp_target),
        .i_exc_valid  (exc_valid),
        .i_exc_pc     (exc_pc),
        .o_pc         (pc),
        .o_pc_plus4   (pc_plus4),
        .o_pc_sel     (pc_sel),
        .o_epc        (epc),
        .o_fetch_valid(fetch_valid),
        .o_flush_if   (flush_if),
        .o_flush_id   (flush_id)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural PC/EPC, whether we are still in the boot
    // cycle, a queue of redirect targets waiting for the outstanding fetch to
    // drain, and (delay-slot build) a deferred target.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_boot;
    logic [31:0] pend_q[$];
    bit          m_dvalid;
    logic [31:0] m_dtgt;

    // DUT observations from the last step, for directed checks.
    logic        s_req, s_fv, s_fif, s_fid;
    logic [1:0]  s_sel;

    task automatic clear_in();
        reset_n    = 1'b1;
        stall      = 1'b0;
        imem_ready = 1'b1;
        br_taken   = 1'b0;
        jmp_valid  = 1'b0;
        exc_valid  = 1'b0;
        br_target  = '0;
        jmp_target = '0;
        exc_pc     = '0;
    endtask

    // Inputs already driven at a negedge; check, advance model, move to next negedge.
    task automatic step();
        logic        e_req, e_fv, e_fif, e_fid, redirect;
        logic [1:0]  sel;
        logic [31:0] tgt, n_pc, n_epc;
        #1;
        e_req = 0; e_fv = 0; e_fif = 0; e_fid = 0; sel = 0; tgt = '0;
        n_pc = m_pc; n_epc = m_epc;
        if (!reset_n) begin
            n_pc = 32'h0; n_epc = 32'h0; m_boot = 1; pend_q.delete(); m_dvalid = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else begin
            e_req = 1;
            if (exc_valid)      begin sel = 3; tgt = 32'h180; end
            else if (br_taken)  begin sel = 2; tgt = {br_target[31:2], 2'b00}; end
            else if (jmp_valid) begin sel = 1; tgt = {jmp_target[31:2], 2'b00}; end
`ifdef DELAY_SLOT_EN
            redirect = exc_valid;
`else
            redirect = (sel != 0);
`endif
            if (redirect) begin
                e_fif = 1;
                e_fid = (sel != 1);
                if (exc_valid) n_epc = exc_pc;
            end
            if (pend_q.size() != 0) begin
                if (redirect) begin pend_q.delete(); pend_q.push_back(tgt); end
                if (imem_ready) n_pc = pend_q.pop_front();
            end else if (redirect) begin
                if (imem_ready) n_pc = tgt;
                else pend_q.push_back(tgt);
            end else if (imem_ready && !stall) begin
                e_fv = 1;
                n_pc = m_pc + 32'd4;
`ifdef DELAY_SLOT_EN
                if (m_dvalid) begin n_pc = m_dtgt; m_dvalid = 0; end
`endif
            end
`ifdef DELAY_SLOT_EN
            if (exc_valid) m_dvalid = 0;
            else if (br_taken || jmp_valid) begin m_dvalid = 1; m_dtgt = tgt; end
`endif
        end
        check_val("pc", pc, m_pc);
        check_val("imem_addr", imem_addr, m_pc);
        check_val("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_val("epc", epc, m_epc);
        check_val("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        check_val("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
        check_val("flush_if", {31'b0, flush_if}, {31'b0, e_fif});
        check_val("flush_id", {31'b0, flush_id}, {31'b0, e_fid});
        check_val("pc_sel", {30'b0, pc_sel}, {30'b0, sel});
        s_req = imem_req; s_fv = fetch_valid; s_fif = flush_if; s_fid = flush_id;
        s_sel = pc_sel;
        m_pc = n_pc; m_epc = n_epc;
        @(negedge clk);
    endtask

    task automatic do_jump(input logic [31:0] t);
        clear_in(); jmp_valid = 1; jmp_target = t; step();
        clear_in();
`ifdef DELAY_SLOT_EN
        step();   // delay slot fetch, then the deferred target lands
`endif
    endtask

    initial begin
        clear_in();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        m_pc = 32'h0; m_epc = 32'h0; m_boot = 1; m_dvalid = 0; m_dtgt = '0;

        // Boot cycle then sequential fetch 0, 4, 8, 12.
        clear_in(); step();
        check_val("boot_req", {31'b0, s_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_val("seq_pc", pc, 32'(i * 4));
            step();
            check_val("seq_fv", {31'b0, s_fv}, 32'd1);
        end

`ifndef DELAY_SLOT_EN
        do_jump(32'h40);
        check_val("jmp_pc", pc, 32'h40);
        clear_in(); br_taken = 1; br_target = 32'h103; step();
        check_val("br_sel", {30'b0, s_sel}, 32'd2);
        check_val("br_flush", {30'b0, s_fif, s_fid}, 32'd3);
        check_val("br_fv", {31'b0, s_fv}, 32'd0);
        check_val("br_pc", pc, 32'h100);
        clear_in(); step();
        check_val("br_flush_once", {30'b0, s_fif, s_fid}, 32'd0);

        clear_in(); exc_valid = 1; exc_pc = 32'h3C; br_taken = 1; br_target = 32'h500;
        jmp_valid = 1; jmp_target = 32'h600; step();
        check_val("exc_sel", {30'b0, s_sel}, 32'd3);
        check_val("exc_pc", pc, 32'h180);
        check_val("exc_epc", epc, 32'h3C);

        do_jump(32'h20);
        clear_in(); jmp_valid = 1; jmp_target = 32'h200; imem_ready = 0; step();
        for (int i = 0; i < 2; i++) begin
            clear_in(); imem_ready = 0; step();
            check_val("hold_pc", pc, 32'h20);
            check_val("hold_fv", {31'b0, s_fv}, 32'd0);
        end
        clear_in(); step();
        check_val("hold_drain_fv", {31'b0, s_fv}, 32'd0);
        check_val("hold_drain_pc", pc, 32'h200);

        do_jump(32'h80);
        for (int i = 0; i < 2; i++) begin
            clear_in(); stall = 1; step();
            check_val("stall_pc", pc, 32'h80);
            check_val("stall_fv", {31'b0, s_fv}, 32'd0);
        end
        clear_in(); step();
        check_val("stall_release_pc", pc, 32'h84);
`else
        // pc is 16; get to 8, then branch with a delay slot.
        do_jump(32'h8);
        check_val("ds_jmp_pc", pc, 32'h8);
        clear_in(); br_taken = 1; br_target = 32'h100; step();
        check_val("ds_flush_if", {31'b0, s_fif}, 32'd0);
        check_val("ds_flush_id", {31'b0, s_fid}, 32'd0);
        check_val("ds_slot_pc", pc, 32'd12);
        clear_in(); step();
        check_val("ds_target_pc", pc, 32'h100);
`endif

        do_jump(32'hFFFF_FFFC);
        check_val("wrap_pre", pc, 32'hFFFF_FFFC);
        clear_in(); step();
        check_val("wrap_pc", pc, 32'h0);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            reset_n    = ($urandom_range(0, 255) != 0);
            stall      = ($urandom_range(0, 7) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            br_taken   = ($urandom_range(0, 9) == 0);
            jmp_valid  = ($urandom_range(0, 9) == 0);
            exc_valid  = ($urandom_range(0, 19) == 0);
            br_target  = $urandom;
            jmp_target = $urandom;
            exc_pc     = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
